// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the CPU hazard scoreboard.
//   CPU_NUM_REGS / CPU_WB_LAT / CPU_JB_LAT / CPU_FWD_CNT / CPU_PERF_W
//                 : default parameter values for cpu_hazard_sb
//   reg_idx_t     : architectural register index for the default register count
//   max_int       : helper used to size the countdown counters
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_NUM_REGS = 16;
    localparam int CPU_WB_LAT   = 4;
    localparam int CPU_JB_LAT   = 3;
    localparam int CPU_FWD_CNT  = 2;
    localparam int CPU_PERF_W   = 32;
    localparam int CPU_RW       = $clog2(CPU_NUM_REGS);

    typedef logic [CPU_RW-1:0] reg_idx_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sb_cnt.sv
// -----------------------------------------------------------------------------
// sb_cnt
// One scoreboard entry: a loadable, freezable down-counter that stops at zero.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the count)
//   load       : load load_val this cycle (takes priority over decrement)
//   load_val   : value to load
//   hold       : freeze the counter (no load, no decrement)
//   count      : current count
//   nonzero    : count != 0
// -----------------------------------------------------------------------------
module sb_cnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          hold,
    output logic [CW-1:0] count,
    output logic          nonzero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!hold) begin
            if (load) begin
                count <= load_val;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/cpu_hazard_sb.sv
// -----------------------------------------------------------------------------
// cpu_hazard_sb
// Pipeline hazard unit between decode and issue. Each architectural register
// has a countdown of cycles until its pending result is committed; a further
// counter tracks the shadow after a jump/branch. The decode instruction issues
// only when none of its sources are pending, no branch shadow is active and
// the downstream pipeline is not stalled. A saturating counter records the
// number of cycles a valid decode instruction was held back.
//
// Optional build macro: CPU_FWD_EN
//   defined   : a source is only a hazard while its producer count is above
//               FWD_CNT (forwarding covers the rest)
//   undefined : a source is a hazard while its producer count is nonzero
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   dec_valid             : decode holds a valid instruction
//   dec_rs1/_en, rs2/_en  : source registers and their read enables
//   dec_rd/_en            : destination register and write enable
//   dec_is_jb             : instruction is a jump/branch
//   ext_stall             : downstream stall, freezes every counter
//   issue                 : instruction issues this cycle
//   rd_wrt_stall          : RAW hazard on a source
//   jb_stall              : branch shadow active
//   busy_regs             : per-register pending-write flags
//   stall_cycles          : saturating count of stalled valid cycles
// -----------------------------------------------------------------------------
module cpu_hazard_sb
    import cpu_pkg::*;
#(
    parameter  int NUM_REGS = CPU_NUM_REGS,
    parameter  int WB_LAT   = CPU_WB_LAT,
    parameter  int JB_LAT   = CPU_JB_LAT,
    parameter  int FWD_CNT  = CPU_FWD_CNT,
    parameter  int PERF_W   = CPU_PERF_W,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [RW-1:0]       dec_rs1,
    input  logic                dec_rs1_en,
    input  logic [RW-1:0]       dec_rs2,
    input  logic                dec_rs2_en,
    input  logic [RW-1:0]       dec_rd,
    input  logic                dec_rd_en,
    input  logic                dec_is_jb,
    input  logic                ext_stall,
    output logic                issue,
    output logic                rd_wrt_stall,
    output logic                jb_stall,
    output logic [NUM_REGS-1:0] busy_regs,
    output logic [PERF_W-1:0]   stall_cycles
);

    localparam int CW = $clog2(max_int(WB_LAT, JB_LAT) + 1);
    // Entries 0..NUM_REGS-1 are registers, entry NUM_REGS is the branch shadow.
    localparam int IW = $clog2(NUM_REGS + 1);

    if (WB_LAT < 1) begin : g_bad_wb_lat
        $error("cpu_hazard_sb: WB_LAT must be at least 1");
    end
    if (JB_LAT < 1) begin : g_bad_jb_lat
        $error("cpu_hazard_sb: JB_LAT must be at least 1");
    end
    if (FWD_CNT >= WB_LAT) begin : g_bad_fwd_cnt
        $error("cpu_hazard_sb: FWD_CNT must be below WB_LAT");
    end

    logic [CW-1:0]   cnt [NUM_REGS+1];
    logic [NUM_REGS:0] cnt_nz;
    logic [NUM_REGS:0] cnt_load;
    logic [IW-1:0]   rs1_ix;
    logic [IW-1:0]   rs2_ix;
    logic [IW-1:0]   rd_ix;
    logic            haz1;
    logic            haz2;

    assign rs1_ix = IW'(dec_rs1);
    assign rs2_ix = IW'(dec_rs2);
    assign rd_ix  = IW'(dec_rd);

    for (genvar g = 0; g <= NUM_REGS; g++) begin : g_cnt
        localparam int LAT = (g == NUM_REGS) ? JB_LAT : WB_LAT;
        sb_cnt #(.CW(CW)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (cnt_load[g]),
            .load_val (CW'(LAT)),
            .hold     (ext_stall),
            .count    (cnt[g]),
            .nonzero  (cnt_nz[g])
        );
    end

    // Hazards look at the registered counts, so a self-dependent instruction
    // sees the older producer and never waits on itself.
    always_comb begin
`ifdef CPU_FWD_EN
        haz1 = dec_rs1_en && (cnt[rs1_ix] > CW'(FWD_CNT));
        haz2 = dec_rs2_en && (cnt[rs2_ix] > CW'(FWD_CNT));
`else
        haz1 = dec_rs1_en && (cnt[rs1_ix] != '0);
        haz2 = dec_rs2_en && (cnt[rs2_ix] != '0);
`endif
    end

    assign rd_wrt_stall = dec_valid && (haz1 || haz2);
    assign jb_stall     = cnt_nz[NUM_REGS];
    assign issue        = dec_valid && !rd_wrt_stall && !jb_stall && !ext_stall;
    assign busy_regs    = cnt_nz[NUM_REGS-1:0];

    // An issuing instruction reloads its destination (also on WAW) and,
    // for jumps/branches, the shadow counter; the load beats the decrement.
    always_comb begin
        cnt_load = '0;
        if (issue) begin
            if (dec_rd_en) begin
                cnt_load[rd_ix] = 1'b1;
            end
            if (dec_is_jb) begin
                cnt_load[NUM_REGS] = 1'b1;
            end
        end
    end

    // Counts every valid cycle that does not issue, ext_stall cycles included,
    // and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (dec_valid && !issue && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_hazard_sb.sv
// -----------------------------------------------------------------------------
// tb_cpu_hazard_sb
// Directed bench for cpu_hazard_sb. A second instance with PERF_W = 4 shares
// all inputs and is used for the stall counter saturation scenario.
// -----------------------------------------------------------------------------
module tb_cpu_hazard_sb;
    import cpu_pkg::*;

    localparam int NUM_REGS = 16;
    localparam int WB_LAT   = 4;
    localparam int JB_LAT   = 3;
    localparam int FWD_CNT  = 2;
`ifdef CPU_FWD_EN
    localparam int EXP_RAW  = WB_LAT - FWD_CNT;
    localparam int EXP_SELF = 0;
`else
    localparam int EXP_RAW  = WB_LAT;
    localparam int EXP_SELF = 2;
`endif

    logic          clk;
    logic          rst;
    logic          dec_valid;
    reg_idx_t      dec_rs1;
    logic          dec_rs1_en;
    reg_idx_t      dec_rs2;
    logic          dec_rs2_en;
    reg_idx_t      dec_rd;
    logic          dec_rd_en;
    logic          dec_is_jb;
    logic          ext_stall;
    logic          issue;
    logic          rd_wrt_stall;
    logic          jb_stall;
    logic [15:0]   busy_regs;
    logic [31:0]   stall_cycles;
    logic          s_issue;
    logic          s_rd_wrt_stall;
    logic          s_jb_stall;
    logic [15:0]   s_busy_regs;
    logic [3:0]    s_stall_cycles;

    int tests;
    int fails;

    cpu_hazard_sb #(
        .NUM_REGS(NUM_REGS), .WB_LAT(WB_LAT), .JB_LAT(JB_LAT),
        .FWD_CNT(FWD_CNT), .PERF_W(32)
    ) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs1_en(dec_rs1_en),
        .dec_rs2(dec_rs2), .dec_rs2_en(dec_rs2_en),
        .dec_rd(dec_rd), .dec_rd_en(dec_rd_en), .dec_is_jb(dec_is_jb),
        .ext_stall(ext_stall), .issue(issue), .rd_wrt_stall(rd_wrt_stall),
        .jb_stall(jb_stall), .busy_regs(busy_regs), .stall_cycles(stall_cycles)
    );

    cpu_hazard_sb #(
        .NUM_REGS(NUM_REGS), .WB_LAT(WB_LAT), .JB_LAT(JB_LAT),
        .FWD_CNT(FWD_CNT), .PERF_W(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs1_en(dec_rs1_en),
        .dec_rs2(dec_rs2), .dec_rs2_en(dec_rs2_en),
        .dec_rd(dec_rd), .dec_rd_en(dec_rd_en), .dec_is_jb(dec_is_jb),
        .ext_stall(ext_stall), .issue(s_issue), .rd_wrt_stall(s_rd_wrt_stall),
        .jb_stall(s_jb_stall), .busy_regs(s_busy_regs), .stall_cycles(s_stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are sampled #1 later,
    // well before the next rising edge.
    task automatic set_instr(input logic v, input int rs1, input logic rs1_en,
                             input int rs2, input logic rs2_en,
                             input int rd, input logic rd_en, input logic jb);
        dec_valid  = v;
        dec_rs1    = reg_idx_t'(rs1);
        dec_rs1_en = rs1_en;
        dec_rs2    = reg_idx_t'(rs2);
        dec_rs2_en = rs2_en;
        dec_rd     = reg_idx_t'(rd);
        dec_rd_en  = rd_en;
        dec_is_jb  = jb;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        ext_stall = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ext_stall = 1'b0;
        set_instr(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (issue !== 1'b1) begin
            fails++; $display("[TB] FAIL reset_issue got %b want 1", issue);
        end
        tests++;
        if ({rd_wrt_stall, jb_stall} !== 2'b00) begin
            fails++; $display("[TB] FAIL reset_stalls got %b%b want 00", rd_wrt_stall, jb_stall);
        end
        tests++;
        if (busy_regs !== 16'h0 || stall_cycles !== 32'd0) begin
            fails++; $display("[TB] FAIL reset_state busy %h stall_cycles %0d want 0 0", busy_regs, stall_cycles);
        end
        @(negedge clk);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_raw();
        int stalls = 0;
        bit issued = 0;
        bit flag_ok = 1;
        do_reset();
        @(negedge clk);
        set_instr(1, 0, 0, 0, 0, 3, 1, 0);
        #1;
        tests++;
        if (issue !== 1'b1) begin
            fails++; $display("[TB] FAIL raw_producer_issue got %b want 1", issue);
        end
        @(negedge clk);
        set_instr(1, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && !issued; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (issue === 1'b1) issued = 1;
            else begin
                stalls++;
                if (rd_wrt_stall !== 1'b1 || busy_regs[3] !== 1'b1) flag_ok = 0;
            end
        end
        tests++;
        if (!issued || stalls != EXP_RAW) begin
            fails++; $display("[TB] FAIL raw_stall_len issued %0d stalls %0d want %0d", issued, stalls, EXP_RAW);
        end
        tests++;
        if (!flag_ok) begin
            fails++; $display("[TB] FAIL raw_flags rd_wrt_stall/busy_regs[3] not set while stalled");
        end
        tests++;
        if (stall_cycles !== 32'(EXP_RAW)) begin
            fails++; $display("[TB] FAIL raw_perf got %0d want %0d", stall_cycles, EXP_RAW);
        end
        @(negedge clk);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_jb_plain();
        int shadow = 0;
        bit issued = 0;
        do_reset();
        @(negedge clk);
        set_instr(1, 0, 0, 0, 0, 0, 0, 1);
        #1;
        tests++;
        if (issue !== 1'b1 || jb_stall !== 1'b0) begin
            fails++; $display("[TB] FAIL jb_issue issue %b jb_stall %b want 1 0", issue, jb_stall);
        end
        @(negedge clk);
        set_instr(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && !issued; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (issue === 1'b1) issued = 1;
            else if (jb_stall === 1'b1) shadow++;
        end
        tests++;
        if (!issued || shadow != JB_LAT) begin
            fails++; $display("[TB] FAIL jb_shadow issued %0d shadow %0d want %0d", issued, shadow, JB_LAT);
        end
        @(negedge clk);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_jb_ext_stall();
        int blocked = 0;
        bit issued = 0;
        do_reset();
        @(negedge clk);
        set_instr(1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        set_instr(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12 && !issued; i++) begin
            if (i > 0) @(negedge clk);
            ext_stall = (i == 1 || i == 2);
            #1;
            if (issue === 1'b1) issued = 1;
            else blocked++;
        end
        tests++;
        if (!issued || blocked != 5) begin
            fails++; $display("[TB] FAIL jb_ext_blocked issued %0d blocked %0d want 5", issued, blocked);
        end
        tests++;
        if (stall_cycles !== 32'd5) begin
            fails++; $display("[TB] FAIL jb_ext_perf got %0d want 5", stall_cycles);
        end
        @(negedge clk);
        ext_stall = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_self_dep();
        int stalls = 0;
        bit issued = 0;
        bit busy_ok = 1;
        do_reset();
        @(negedge clk);
        set_instr(1, 0, 0, 0, 0, 5, 1, 0);
        @(negedge clk);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        set_instr(1, 5, 1, 0, 0, 5, 1, 0);
        for (int i = 0; i < 10 && !issued; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (issue === 1'b1) issued = 1;
            else stalls++;
        end
        tests++;
        if (!issued || stalls != EXP_SELF) begin
            fails++; $display("[TB] FAIL self_dep_stall issued %0d stalls %0d want %0d", issued, stalls, EXP_SELF);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            set_instr(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (busy_regs[5] !== (k <= WB_LAT)) busy_ok = 0;
        end
        tests++;
        if (!busy_ok) begin
            fails++; $display("[TB] FAIL self_dep_reload busy_regs[5] did not stay set for %0d cycles after reload", WB_LAT);
        end
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        bit issued = 0;
        do_reset();
        @(negedge clk);
        set_instr(1, 0, 0, 0, 0, 2, 1, 0);
        @(negedge clk);
        set_instr(1, 2, 0, 9, 1, 2, 1, 0);
        #1;
        tests++;
        if (issue !== 1'b1) begin
            fails++; $display("[TB] FAIL b2b_waw_issue got %b want 1", issue);
        end
        @(negedge clk);
        set_instr(1, 0, 0, 2, 1, 0, 0, 0);
        for (int i = 0; i < 10 && !issued; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (issue === 1'b1) issued = 1;
            else stalls++;
        end
        tests++;
        if (!issued || stalls != EXP_RAW) begin
            fails++; $display("[TB] FAIL b2b_rs2_stall issued %0d stalls %0d want %0d", issued, stalls, EXP_RAW);
        end
        @(negedge clk);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        @(negedge clk);
        set_instr(1, 0, 0, 0, 0, 7, 1, 1);
        @(negedge clk);
        set_instr(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        tests++;
        if (busy_regs[7] !== 1'b1 || jb_stall !== 1'b1 || stall_cycles !== 32'd1) begin
            fails++; $display("[TB] FAIL mid_pre busy7 %b jb %b perf %0d want 1 1 1", busy_regs[7], jb_stall, stall_cycles);
        end
        rst = 1'b1;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (busy_regs !== 16'h0 || jb_stall !== 1'b0 || stall_cycles !== 32'd0) begin
            fails++; $display("[TB] FAIL mid_reset busy %h jb %b perf %0d want 0 0 0", busy_regs, jb_stall, stall_cycles);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        @(negedge clk);
        ext_stall = 1'b1;
        set_instr(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        ext_stall = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        tests++;
        if (s_stall_cycles !== 4'd15) begin
            fails++; $display("[TB] FAIL perf_saturate got %0d want 15", s_stall_cycles);
        end
        tests++;
        if (stall_cycles !== 32'd20) begin
            fails++; $display("[TB] FAIL perf_wide got %0d want 20", stall_cycles);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        ext_stall = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_raw();
        test_jb_plain();
        test_jb_ext_stall();
        test_self_dep();
        test_back_to_back();
        test_mid_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_hazard_sb.md
Name: cpu_hazard_sb

Overview:
Parametrised pipeline hazard unit for the CPU. It replaces the fixed five-stage combinational stall compare with a per-register countdown scoreboard and a branch shadow counter.
- Sits between fetch/decode and issue.
- Decides each cycle whether the instruction at decode may issue, or must stall for a register RAW hazard or an unresolved jump/branch.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
NUM_REGS, 16, architectural register count; index width RW = $clog2(NUM_REGS)
WB_LAT, 4, cycles from issue until the result is committed in the register file (>=1)
JB_LAT, 3, cycles issue is held after a jump/branch issues (>=1)
FWD_CNT, 2, producer counter value at or below which forwarding covers the operand (< WB_LAT); used only with CPU_FWD_EN
PERF_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dec_valid  in  1  decode holds a valid instruction
dec_rs1  in  RW  source register 1
dec_rs1_en  in  1  rs1 is read
dec_rs2  in  RW  source register 2
dec_rs2_en  in  1  rs2 is read
dec_rd  in  RW  destination register
dec_rd_en  in  1  instruction writes rd
dec_is_jb  in  1  instruction is jump/branch
ext_stall  in  1  downstream (memory) stall; freezes the unit
issue  out  1  decode instruction issues this cycle
rd_wrt_stall  out  1  RAW hazard on rs1/rs2
jb_stall  out  1  branch shadow active
busy_regs  out  NUM_REGS  bit r set iff cnt[r] != 0
stall_cycles  out  PERF_W  saturating count of stalled valid cycles

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- State:
  - cnt[r] for r in 0..NUM_REGS-1
  - jb_cnt
  - stall_cycles
  - Counter width CW = $clog2(max(WB_LAT,JB_LAT)+1).
- Reset: all cnt = 0, jb_cnt = 0, stall_cycles = 0. Hence issue = dec_valid, rd_wrt_stall = 0, jb_stall = 0, busy_regs = 0.
  - Reset mid-operation discards all pending writes and branch shadows.
- Hazard terms (combinational from registered state):
  - haz1 = dec_rs1_en & (cnt[dec_rs1] != 0)
  - haz2 likewise for rs2
  - rd_wrt_stall = dec_valid & (haz1 | haz2)
  - jb_stall = (jb_cnt != 0)
- issue = dec_valid & !rd_wrt_stall & !jb_stall & !ext_stall. Zero-latency decision, no handshake state.
- Per cycle when ext_stall = 0:
  - Every nonzero cnt[r] decrements by 1.
  - Nonzero jb_cnt decrements by 1.
  - Then, if issue:
    - dec_rd_en sets cnt[dec_rd] = WB_LAT. Issue wins over decrement on the same entry.
    - dec_is_jb sets jb_cnt = JB_LAT.
- ext_stall = 1: all cnt and jb_cnt hold; no issue.
- Counter = 1 still stalls that cycle; the dependant issues the next cycle. RAW penalty after back-to-back issue is WB_LAT cycles.
- Self-dependency (rd == rs, e.g. r3 = r3 + 1) checks the old cnt, so it is not a hazard with itself.
- Newer write to a busy rd (WAW) reloads cnt to WB_LAT. This is safe because latency is fixed and in order.
- jb issue: 0 stall in the issue cycle, then exactly JB_LAT stall cycles.
- A jb instruction that also writes rd sets both counters.
- stall_cycles increments when dec_valid & !issue, including ext_stall cycles. It saturates at all-ones and does not wrap.
- Elaboration assertions: WB_LAT >= 1, JB_LAT >= 1, FWD_CNT < WB_LAT.

Optional Feature:
CPU_FWD_EN
- Defined: haz uses cnt[rs] > FWD_CNT, i.e. the producer is still earlier than the forwarding stage. RAW penalty after back-to-back issue becomes WB_LAT-FWD_CNT cycles.
- Undefined: haz uses cnt[rs] != 0 (no forwarding).
- busy_regs is unchanged in both builds.

Decomposition:
- cpu_pkg holds:
  - default constants CPU_NUM_REGS, CPU_WB_LAT, CPU_JB_LAT
  - typedef reg_idx_t (logic [RW-1:0])
- One sub-module, sb_cnt: a single loadable, freezable down-counter with load value, load enable, hold, and nonzero flag.
  - The top instantiates NUM_REGS of them plus one for jb_cnt.

Test Plan:
1. Reset, then dec_valid=1 with no sources -> issue=1, all stalls 0, stall_cycles=0.
2. Issue r3 write, next cycle instruction reads r3 (no FWD) -> rd_wrt_stall=1 for 4 cycles, issue on 5th; stall_cycles=4.
3. Same as scenario 2 with CPU_FWD_EN, FWD_CNT=2 -> stall 2 cycles, issue on 3rd.
4. Issue jb -> jb_stall=1 for exactly 3 cycles. Assert ext_stall during the 2nd cycle for 2 cycles -> jb_cnt frozen, total 5 blocked cycles.
5. r5 busy (cnt=2) and instruction reads r5 while writing r5 -> stall 2 cycles, then issue reloads cnt[5]=4; busy_regs bit5 stays set.
6. rst asserted while cnt[7]=3 and jb_cnt=2 -> next cycle busy_regs=0, jb_stall=0, stall_cycles=0. With PERF_W=4, forced 20 stalls -> stall_cycles holds at 15.
